// File: rtl/div_rem_nb.sv
// div_rem_nb: iterative restoring N-bit divider (RISC-V DIV/DIVU/REM/REMU rules), valid/ready on both sides.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass the iteration.
module div_rem_nb #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         signed_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] quot_o,
    output logic [N-1:0] rem_o
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   div_q, div_d;
    logic [N-1:0]   r_q, r_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_q, last_d;
    logic           negq_q, negq_d;
    logic           negr_q, negr_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   a_mag, b_mag, r_sub;
    logic [N:0]     r_sh;
    logic           ge;

    always_comb begin
        a_mag       = (signed_i && a_i[N-1]) ? -a_i : a_i;
        b_mag       = (signed_i && b_i[N-1]) ? -b_i : b_i;
        r_sh        = {r_q, acc_q[N-1]};
        ge          = r_sh >= {1'b0, div_q};
        r_sub       = r_sh[N-1:0] - div_q;
        state_d     = state_q;
        acc_d       = acc_q;
        div_d       = div_q;
        r_d         = r_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        out_valid_d = out_valid_q;
        if (state_q == IDLE && in_valid_i) begin
            state_d = CALC;
            cnt_d   = CW'(N - 1);
            last_d  = 1'b0;
            acc_d   = a_mag;
            div_d   = b_mag;
            r_d     = '0;
            negq_d  = signed_i && (a_i[N-1] ^ b_i[N-1]) && (b_i != '0);
            negr_d  = signed_i && a_i[N-1];
`ifdef DIV_EARLY_OUT_EN
            // Special results are preloaded unsigned; the fix-up cycle then just registers them.
            if (b_i == '0 || (signed_i && a_i == {1'b1, {(N-1){1'b0}}} && b_i == '1)) begin
                last_d = 1'b1;
                acc_d  = (b_i == '0) ? '1 : {1'b1, {(N-1){1'b0}}};
                r_d    = (b_i == '0) ? a_i : '0;
                negq_d = 1'b0;
                negr_d = 1'b0;
            end
`endif
        end else if (state_q == CALC && !last_q) begin
            acc_d  = {acc_q[N-2:0], ge};
            r_d    = ge ? r_sub : r_sh[N-1:0];
            cnt_d  = cnt_q - CW'(1);
            last_d = cnt_q == '0;
        end else if (state_q == CALC) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quot_d      = negq_q ? -acc_q : acc_q;
            rem_d       = negr_q ? -r_q : r_q;
        end else if (state_q == DONE && out_ready_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            div_q       <= '0;
            r_q         <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            div_q       <= div_d;
            r_q         <= r_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = state_q == IDLE;
    assign out_valid_o = out_valid_q;
    assign quot_o      = quot_q;
    assign rem_o       = rem_q;
endmodule

// File: tb/tb_div_rem_nb.sv
// tb_div_rem_nb: directed vectors for div_rem_nb (N = 32) with hand-computed quotient, remainder and latency.
module tb_div_rem_nb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sgn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] quot, rem;
    int          checks = 0;
    int          errors = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif

    div_rem_nb #(.N(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .signed_i   (sgn),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input string tag, input logic [31:0] av, input logic [31:0] bv, input logic s);
        @(negedge clk);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        a = av;
        b = bv;
        sgn = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h0000_1234;
        sgn = ~s;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic op(input string tag, input logic [31:0] av, input logic [31:0] bv, input logic s,
                      input logic [31:0] eq, input logic [31:0] er, input int lat);
        int n;
        start(tag, av, bv, s);
        wait_valid(n);
        check({tag, "_lat"}, n, lat);
        check({tag, "_quot"}, quot, eq);
        check({tag, "_rem"}, rem, er);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        #2;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_quot", quot, 32'd0);
        check("rst_rem", rem, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op("udiv",      32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         33);
        op("sdiv_na",   32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        op("sdiv_nb",   32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         33);
        op("sdiv_nn",   32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE, 33);
        op("udiv0",     32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         SPEC_LAT);
        op("sdiv0",     32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF, 32'd5,         SPEC_LAT);
        op("sdiv0_neg", 32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, SPEC_LAT);
        op("sovf",      32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         SPEC_LAT);
        op("uext",      32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 33);

        out_ready = 1'b0;
        start("bp", 32'd100, 32'd7, 1'b0);
        wait_valid(n);
        check("bp_lat", n, 33);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            a = 32'd1000;
            b = 32'd3;
            @(posedge clk);
            #1;
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_quot", quot, 32'd14);
            check("bp_rem", rem, 32'd2);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_back", {31'b0, in_ready}, 32'd1);
        check("bp_valid_drop", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("bp_no_accept", {31'b0, in_ready}, 32'd1);

        start("mid", 32'h1234_5678, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_quot", quot, 32'd0);
        check("mid_rem", rem, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op("post_rst", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
